// File: rtl/pll_pkg.sv
// rtl/pll_pkg.sv - shared types and defaults for the PLL reset sequencer
package pll_pkg;

  typedef enum logic [1:0] {
    ST_WAIT = 2'd0,
    ST_QUAL = 2'd1,
    ST_CORE = 2'd2,
    ST_RUN  = 2'd3
  } pll_seq_state_t;

  localparam int PLL_STABLE_CYCLES = 1024;
  localparam int PLL_STAGE_GAP     = 16;

endpackage

// File: rtl/sync2.sv
// rtl/sync2.sv - generic two-flop synchronizer with async active-low reset
module sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/pll_reset_seq.sv
// rtl/pll_reset_seq.sv - qualifies PLL lock and releases core then peripheral resets
module pll_reset_seq
  import pll_pkg::*;
#(
  parameter int STABLE_CYCLES = PLL_STABLE_CYCLES,
  parameter int STAGE_GAP     = PLL_STAGE_GAP,
  parameter int CNT_W         = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             locked,
  input  logic             clear_loss,
  output logic             lock_ok,
  output logic             rst_core_n,
  output logic             rst_periph_n,
  output logic [CNT_W-1:0] loss_count,
  output logic             lock_lost
);

  localparam int QW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam int GW = (STAGE_GAP > 1) ? $clog2(STAGE_GAP) : 1;
  localparam logic [QW-1:0] QLAST = QW'(STABLE_CYCLES - 1);
  localparam logic [GW-1:0] GLAST = GW'(STAGE_GAP - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic locked_s;

  pll_seq_state_t   state_q, state_d;
  logic [QW-1:0]    qcnt_q, qcnt_d;
  logic [GW-1:0]    gcnt_q, gcnt_d;
  logic             loss_evt;
  logic             core_d, periph_d;
  logic [CNT_W-1:0] cnt_d;
  logic             lost_d;

  sync2 #(.WIDTH(1)) u_sync (
    .clock   (clock),
    .reset_n (reset_n),
    .d       (locked),
    .q       (locked_s)
  );

  always_comb begin
    state_d  = state_q;
    qcnt_d   = qcnt_q;
    gcnt_d   = gcnt_q;
    loss_evt = 1'b0;
    case (state_q)
      ST_WAIT: begin
        if (locked_s) begin
          state_d = ST_QUAL;
          qcnt_d  = QW'(1);
        end else begin
          qcnt_d = '0;
        end
      end
      ST_QUAL: begin
        if (!locked_s) begin
          state_d = ST_WAIT;
          qcnt_d  = '0;
        end else if (qcnt_q == QLAST) begin
          state_d = ST_CORE;
          gcnt_d  = '0;
        end else begin
          qcnt_d = qcnt_q + QW'(1);
        end
      end
      ST_CORE: begin
        if (!locked_s) begin
          state_d  = ST_WAIT;
          qcnt_d   = '0;
          loss_evt = 1'b1;
        end else if (gcnt_q == GLAST) begin
          state_d = ST_RUN;
        end else begin
          gcnt_d = gcnt_q + GW'(1);
        end
      end
      ST_RUN: begin
        if (!locked_s) begin
          state_d  = ST_WAIT;
          qcnt_d   = '0;
          loss_evt = 1'b1;
        end
      end
      default: begin
        state_d = ST_WAIT;
        qcnt_d  = '0;
        gcnt_d  = '0;
      end
    endcase
  end

  // Outputs are registered from the next state so they move on the same edge as the state.
  always_comb begin
    core_d   = (state_d == ST_CORE) || (state_d == ST_RUN);
    periph_d = (state_d == ST_RUN);
  end

  // A loss on the same edge as a clear wins, leaving a single counted loss.
  always_comb begin
    cnt_d  = loss_count;
    lost_d = lock_lost;
    if (loss_evt) begin
      lost_d = 1'b1;
      if (clear_loss) begin
        cnt_d = CNT_W'(1);
      end else if (loss_count != CNT_MAX) begin
        cnt_d = loss_count + CNT_W'(1);
      end
    end else if (clear_loss) begin
      cnt_d  = '0;
      lost_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_WAIT;
      qcnt_q       <= '0;
      gcnt_q       <= '0;
      lock_ok      <= 1'b0;
      rst_core_n   <= 1'b0;
      rst_periph_n <= 1'b0;
      loss_count   <= '0;
      lock_lost    <= 1'b0;
    end else begin
      state_q      <= state_d;
      qcnt_q       <= qcnt_d;
      gcnt_q       <= gcnt_d;
      lock_ok      <= core_d;
      rst_core_n   <= core_d;
      rst_periph_n <= periph_d;
      loss_count   <= cnt_d;
      lock_lost    <= lost_d;
    end
  end

endmodule

// File: tb/tb_pll_reset_seq.sv
// tb/tb_pll_reset_seq.sv - self-checking bench for pll_reset_seq
module tb_pll_reset_seq;

  localparam int S  = 8;
  localparam int G  = 4;
  localparam int CW = 2;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          locked;
  logic          clear_loss;
  logic          lock_ok;
  logic          rst_core_n;
  logic          rst_periph_n;
  logic [CW-1:0] loss_count;
  logic          lock_lost;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference: locked_s at an edge is the raw locked sampled two edges earlier;
  // a streak of S high locked_s edges releases core, S+G releases peripherals.
  logic m_l1, m_l2;
  int   m_streak;
  int   m_cnt;
  logic m_lost;

  pll_reset_seq #(.STABLE_CYCLES(S), .STAGE_GAP(G), .CNT_W(CW)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .locked       (locked),
    .clear_loss   (clear_loss),
    .lock_ok      (lock_ok),
    .rst_core_n   (rst_core_n),
    .rst_periph_n (rst_periph_n),
    .loss_count   (loss_count),
    .lock_lost    (lock_lost)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_l1 = 1'b0; m_l2 = 1'b0; m_streak = 0; m_cnt = 0; m_lost = 1'b0;
  endtask

  task automatic model_edge(input logic lk, input logic clr);
    logic ls, loss;
    ls   = m_l2;
    m_l2 = m_l1;
    m_l1 = lk;
    loss = !ls && (m_streak >= S);
    m_streak = ls ? m_streak + 1 : 0;
    if (loss) begin
      m_lost = 1'b1;
      m_cnt  = clr ? 1 : ((m_cnt < 3) ? m_cnt + 1 : 3);
    end else if (clr) begin
      m_cnt  = 0;
      m_lost = 1'b0;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".rst_core_n"},   32'(rst_core_n),   32'(m_streak >= S));
    chk({tag, ".rst_periph_n"}, 32'(rst_periph_n), 32'(m_streak >= S + G));
    chk({tag, ".lock_ok"},      32'(lock_ok),      32'(m_streak >= S));
    chk({tag, ".loss_count"},   32'(loss_count),   32'(m_cnt));
    chk({tag, ".lock_lost"},    32'(lock_lost),    32'(m_lost));
  endtask

  task automatic step(input logic lk, input logic clr);
    locked     = lk;
    clear_loss = clr;
    @(posedge clock);
    model_edge(lk, clr);
    @(negedge clock);
    check_all("step");
  endtask

  task automatic steps(input logic lk, input int n);
    for (int i = 0; i < n; i++) step(lk, 1'b0);
  endtask

  initial begin
    int cnt;
    bit done;
    int run_len;
    logic lv;

    reset_n = 1'b0; locked = 1'b0; clear_loss = 1'b0;
    model_reset();
    repeat (3) @(negedge clock);
    check_all("reset");
    reset_n = 1'b1;

    // Clean lock: edges 1..9 low, locked rises before edge 10.
    steps(1'b0, 9);
    cnt = 0; done = 0;
    for (int i = 0; i < 30 && !done; i++) begin
      step(1'b1, 1'b0); cnt++;
      if (rst_core_n === 1'b1) done = 1;
    end
    chk("core_latency", 32'(cnt), 32'(2 + S));
    cnt = 0; done = 0;
    for (int i = 0; i < 30 && !done; i++) begin
      step(1'b1, 1'b0); cnt++;
      if (rst_periph_n === 1'b1) done = 1;
    end
    chk("periph_gap", 32'(cnt), 32'(G));
    chk("clean_loss_count", 32'(loss_count), 32'd0);
    steps(1'b1, 5);

    // Loss in RUN.
    cnt = 0; done = 0;
    for (int i = 0; i < 30 && !done; i++) begin
      step(1'b0, 1'b0); cnt++;
      if (rst_core_n === 1'b0) done = 1;
    end
    chk("loss_latency", 32'(cnt), 32'd3);
    chk("loss_periph", 32'(rst_periph_n), 32'd0);
    chk("loss_lock_ok", 32'(lock_ok), 32'd0);
    chk("loss_lost", 32'(lock_lost), 32'd1);
    chk("loss_count1", 32'(loss_count), 32'd1);
    steps(1'b0, 2);

    // Glitch during qualification restarts the count and is not a loss.
    steps(1'b1, 4);
    step(1'b0, 1'b0);
    cnt = 0; done = 0;
    for (int i = 0; i < 30 && !done; i++) begin
      step(1'b1, 1'b0); cnt++;
      if (rst_core_n === 1'b1) done = 1;
    end
    chk("glitch_relatency", 32'(cnt), 32'(2 + S));
    chk("glitch_no_loss", 32'(loss_count), 32'd1);
    steps(1'b1, 6);

    // Saturation then clear.
    step(1'b1, 1'b1);
    chk("clear0", 32'(loss_count), 32'd0);
    for (int k = 0; k < 4; k++) begin
      steps(1'b0, 3);
      steps(1'b1, S + G + 3);
    end
    chk("saturated", 32'(loss_count), 32'd3);
    step(1'b1, 1'b1);
    chk("clear_cnt", 32'(loss_count), 32'd0);
    chk("clear_lost", 32'(lock_lost), 32'd0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    chk("clear_vs_loss_cnt", 32'(loss_count), 32'd1);
    chk("clear_vs_loss_lost", 32'(lock_lost), 32'd1);

    // Async reset mid-CORE.
    steps(1'b1, S + 3);
    chk("in_core", 32'({rst_core_n, rst_periph_n}), 32'b10);
    #2 reset_n = 1'b0;
    #1;
    chk("async_core", 32'(rst_core_n), 32'd0);
    chk("async_lock_ok", 32'(lock_ok), 32'd0);
    chk("async_cnt", 32'(loss_count), 32'd0);
    chk("async_lost", 32'(lock_lost), 32'd0);
    chk("async_periph", 32'(rst_periph_n), 32'd0);
    @(negedge clock);
    model_reset();
    reset_n = 1'b1;
    cnt = 0; done = 0;
    for (int i = 0; i < 30 && !done; i++) begin
      step(1'b1, 1'b0); cnt++;
      if (rst_core_n === 1'b1) done = 1;
    end
    chk("post_reset_latency", 32'(cnt), 32'(2 + S));

    // Randomized runs of lock/unlock with occasional clears.
    for (int r = 0; r < 150; r++) begin
      lv = 1'($urandom_range(0, 1));
      run_len = lv ? $urandom_range(1, 25) : $urandom_range(1, 5);
      for (int i = 0; i < run_len; i++)
        step(lv, ($urandom_range(0, 15) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
